// File: rtl/sdp_ram_lane_clr.sv
// ---------------------------------------------------------------------------
// sdp_ram_lane_clr
//
// Single-clock simple dual-port RAM with per-lane write enables, a read
// pipeline of one or two register stages, and a counter-driven clear engine.
// The clear engine walks every address after reset or on request, so the
// storage array itself needs no reset.
//
// Optional feature macro: SDP_RAM_BYPASS_EN
//   defined     -> write-first. A same-cycle, same-address read sees the
//                  lane-merged result: new data on enabled lanes, old data
//                  on the others.
//   not defined -> read-first. The read returns the pre-write contents.
//
// Parameters:
//   RAM_WIDTH     data width, must be a multiple of LANE_WIDTH
//   LANE_WIDTH    bits per write lane
//   ADDR_WIDTH    address bits, DEPTH = 2**ADDR_WIDTH
//   READ_LATENCY  1 or 2 cycles from accepted read to read_valid
//   INIT_VALUE    word written to every address by the clear engine
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   clear_req      single-cycle request to start a clear sequence
//   busy           high while the clear engine owns the array
//   write_allow    write enable
//   write_addr     write address
//   write_lane_en  per-lane write mask
//   write_data     write data
//   read_allow     read enable
//   read_addr      read address
//   read_data      read data, holds its last value between reads
//   read_valid     one-cycle pulse when read_data holds a new word
// ---------------------------------------------------------------------------
module sdp_ram_lane_clr #(
  parameter int                 RAM_WIDTH    = 16,
  parameter int                 LANE_WIDTH   = 8,
  parameter int                 ADDR_WIDTH   = 4,
  parameter int                 READ_LATENCY = 1,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_req,
  output logic                            busy,
  input  logic                            write_allow,
  input  logic [ADDR_WIDTH-1:0]           write_addr,
  input  logic [RAM_WIDTH/LANE_WIDTH-1:0] write_lane_en,
  input  logic [RAM_WIDTH-1:0]            write_data,
  input  logic                            read_allow,
  input  logic [ADDR_WIDTH-1:0]           read_addr,
  output logic [RAM_WIDTH-1:0]            read_data,
  output logic                            read_valid
);

  localparam int LANES = RAM_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  // Reject unsupported configurations at elaboration time.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sdp_ram_lane_clr: READ_LATENCY must be 1 or 2");
  end
  if (RAM_WIDTH % LANE_WIDTH != 0) begin : g_bad_lanes
    $error("sdp_ram_lane_clr: RAM_WIDTH must be a multiple of LANE_WIDTH");
  end

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [RAM_WIDTH-1:0]  memory [DEPTH];
  logic [RAM_WIDTH-1:0]  read_word;
  logic                  write_fire;
  logic                  read_fire;
  logic                  s1_valid;
  logic [RAM_WIDTH-1:0]  s1_data;

  assign busy = (state == CLEAR);

  // A clear request wins over a write in the same cycle, but a read in that
  // cycle still completes because it only observes the array.
  assign write_fire = (state == IDLE) && write_allow && !clear_req;
  assign read_fire  = (state == IDLE) && read_allow;

  // Clear engine: reset lands in CLEAR at address 0, so a reset in the
  // middle of a sequence restarts it from the beginning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Storage array. While clearing, the engine has exclusive write access;
  // otherwise each enabled lane of the addressed word takes new data.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      memory[clr_cnt] <= INIT_VALUE;
    end else if (write_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if (write_lane_en[k]) begin
          memory[write_addr][k*LANE_WIDTH +: LANE_WIDTH] <= write_data[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Word presented to the first read stage. With bypass enabled, lanes being
  // written to the same address this cycle are forwarded from write_data.
  always_comb begin
    read_word = memory[read_addr];
`ifdef SDP_RAM_BYPASS_EN
    if (write_fire && (write_addr == read_addr)) begin
      for (int k = 0; k < LANES; k++) begin
        if (write_lane_en[k]) begin
          read_word[k*LANE_WIDTH +: LANE_WIDTH] = write_data[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
`endif
  end

  // First read stage; data is only loaded on an accepted read so the output
  // holds its last word between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= read_fire;
      if (read_fire) begin
        s1_data <= read_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                 s2_valid;
    logic [RAM_WIDTH-1:0] s2_data;

    // Optional output register, same hold-on-idle behaviour as stage one.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign read_valid = s2_valid;
    assign read_data  = s2_data;
  end else begin : g_lat1
    assign read_valid = s1_valid;
    assign read_data  = s1_data;
  end

endmodule

// File: tb/tb_sdp_ram_lane_clr.sv
// ---------------------------------------------------------------------------
// tb_sdp_ram_lane_clr
//
// Directed self-checking bench for sdp_ram_lane_clr. Two instances share all
// inputs: one with READ_LATENCY=1 (primary) and one with READ_LATENCY=2.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sdp_ram_lane_clr;

  localparam int RW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          write_allow;
  logic [AW-1:0] write_addr;
  logic [1:0]    write_lane_en;
  logic [RW-1:0] write_data;
  logic          read_allow;
  logic [AW-1:0] read_addr;

  logic          busy;
  logic [RW-1:0] read_data;
  logic          read_valid;
  logic          busy2;
  logic [RW-1:0] read_data2;
  logic          read_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdp_ram_lane_clr #(
    .RAM_WIDTH(RW), .LANE_WIDTH(8), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_VALUE(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy),
    .write_allow(write_allow), .write_addr(write_addr), .write_lane_en(write_lane_en),
    .write_data(write_data), .read_allow(read_allow), .read_addr(read_addr),
    .read_data(read_data), .read_valid(read_valid)
  );

  sdp_ram_lane_clr #(
    .RAM_WIDTH(RW), .LANE_WIDTH(8), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_VALUE(16'h0000)
  ) dut_lat2 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy2),
    .write_allow(write_allow), .write_addr(write_addr), .write_lane_en(write_lane_en),
    .write_data(write_data), .read_allow(read_allow), .read_addr(read_addr),
    .read_data(read_data2), .read_valid(read_valid2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle worth of inputs, then advance to the next falling edge.
  task automatic applyStimulus(input logic wa, input logic [AW-1:0] wad, input logic [1:0] lanes,
                               input logic [RW-1:0] wd, input logic ra, input logic [AW-1:0] rad,
                               input logic creq);
    write_allow   = wa;
    write_addr    = wad;
    write_lane_en = lanes;
    write_data    = wd;
    read_allow    = ra;
    read_addr     = rad;
    clear_req     = creq;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [RW-1:0] d, input logic [1:0] lanes);
    applyStimulus(1'b1, a, lanes, d, 1'b0, '0, 1'b0);
  endtask

  // Single read: valid must pulse for exactly one cycle with the right word.
  task automatic doRead(input logic [AW-1:0] a, input logic [RW-1:0] expected, input string tag);
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, a, 1'b0);
    checkOutput({tag, " valid"}, 32'(read_valid), 32'd1);
    checkOutput({tag, " data"}, 32'(read_data), 32'(expected));
    idleCycle();
    checkOutput({tag, " valid drop"}, 32'(read_valid), 32'd0);
  endtask

  // Count falling edges while busy stays high, bounded so a stuck engine
  // still reaches the summary.
  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 40) begin
      idleCycle();
      n++;
    end
  endtask

  initial begin
    int n;
    logic seen_valid;
    logic [RW-1:0] words [3];

    words[0] = 16'h0A0A;
    words[1] = 16'h1B1B;
    words[2] = 16'h2C2C;

    rst_n         = 1'b1;
    clear_req     = 1'b0;
    write_allow   = 1'b0;
    write_addr    = '0;
    write_lane_en = 2'b00;
    write_data    = '0;
    read_allow    = 1'b0;
    read_addr     = '0;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd1);
    checkOutput("reset read_valid", 32'(read_valid), 32'd0);
    checkOutput("reset read_data", 32'(read_data), 32'd0);
    checkOutput("reset read_data lat2", 32'(read_data2), 32'd0);

    // Clear after reset release lasts DEPTH edges
    rst_n = 1'b1;
    countBusy(n);
    checkOutput("post-reset busy edges", 32'(n), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      doRead(AW'(a), 16'h0000, $sformatf("init rd %0d", a));
    end

    // Lane masking
    doWrite(4'd3, 16'h1234, 2'b11);
    doWrite(4'd3, 16'hABCD, 2'b01);
    doRead(4'd3, 16'h12CD, "lane merge");
    doWrite(4'd3, 16'hFFFF, 2'b00);
    doRead(4'd3, 16'h12CD, "lane none");

    // Same-cycle read/write on one address
    doWrite(4'd5, 16'h1111, 2'b11);
    applyStimulus(1'b1, 4'd5, 2'b10, 16'hBEEF, 1'b1, 4'd5, 1'b0);
`ifdef SDP_RAM_BYPASS_EN
    checkOutput("collision rd", 32'(read_data), 32'h0000BE11);
`else
    checkOutput("collision rd", 32'(read_data), 32'h00001111);
`endif
    idleCycle();
    doRead(4'd5, 16'hBE11, "collision after");

    // Fill, then clear request with a simultaneous write
    for (int a = 0; a < DEPTH; a++) begin
      doWrite(AW'(a), 16'hA000 + 16'(a), 2'b11);
    end
    doRead(4'd7, 16'hA007, "fill rd 7");
    applyStimulus(1'b1, 4'd7, 2'b11, 16'h5555, 1'b0, '0, 1'b1);
    checkOutput("clear busy rise", 32'(busy), 32'd1);
    n = 0;
    seen_valid = 1'b0;
    while (busy && n < 40) begin
      // A second request mid-sequence must not restart the count.
      applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 4'd7, (n == 5));
      if (read_valid) seen_valid = 1'b1;
      n++;
    end
    idleCycle();
    checkOutput("clear busy edges", 32'(n), 32'(DEPTH));
    checkOutput("clear no read_valid", 32'(seen_valid), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      doRead(AW'(a), 16'h0000, $sformatf("clr rd %0d", a));
    end

    // Reset in the middle of a clear
    doWrite(4'd2, 16'h7777, 2'b11);
    doRead(4'd2, 16'h7777, "pre-rst rd");
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) idleCycle();
    checkOutput("mid-clear busy", 32'(busy), 32'd1);
    checkOutput("mid-clear data hold", 32'(read_data), 32'h7777);
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst read_valid", 32'(read_valid), 32'd0);
    checkOutput("mid rst read_data", 32'(read_data), 32'd0);
    checkOutput("mid rst read_data lat2", 32'(read_data2), 32'd0);
    idleCycle();
    idleCycle();
    checkOutput("mid rst busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    countBusy(n);
    checkOutput("mid rst busy edges", 32'(n), 32'(DEPTH));

    // Back-to-back reads on both latencies
    for (int a = 0; a < 3; a++) doWrite(AW'(a), words[a], 2'b11);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, AW'(i), 1'b0);
      else       idleCycle();
      checkOutput($sformatf("lat1 valid %0d", i), 32'(read_valid), (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) checkOutput($sformatf("lat1 data %0d", i), 32'(read_data), 32'(words[i]));
      checkOutput($sformatf("lat2 valid %0d", i), 32'(read_valid2), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 3) checkOutput($sformatf("lat2 data %0d", i), 32'(read_data2), 32'(words[i-1]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
